ddr3_test_status_reporter: RTL and testbench

Downstream consumer of the DDR3 Avalon read/write test driver's status outputs. It detects test start and completion, measures run duration in iCLK cycles, keeps saturating pass/fail run counters across driver re-runs, and drives the board LEDs: steady init-done, blinking busy, latched pass/fail. Sits between the test driver status outputs and the top-level LED and debug pins.

---
 rtl/ddr3_test_status_reporter.sv | 168 ++++++++++++++++
 tb/tb_ddr3_test_status_reporter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_test_status_reporter.sv
// ddr3_test_status_reporter
// Watches the DDR3 test driver's status flags, times each run in iCLK cycles,
// keeps saturating pass/fail run counters and drives the board LEDs.
// Optional watchdog: define DDR_TEST_TIMEOUT_EN to end runs that reach
// TIMEOUT_CYCLES without completion (counted as a failure, oTIMEOUT set).
//
// FSM: IDLE -> RUN on init done + non-idle driver state; RUN -> DONE on
// completion (or watchdog); RUN -> IDLE on driver reset; DONE -> IDLE when
// the driver returns to state 0. Inputs are sampled on every rising edge,
// there is no handshake or back-pressure: a level seen on an edge is acted
// on at that edge.
module ddr3_test_status_reporter #(
  parameter int               CNT_W          = 40,
  parameter int               BLINK_W        = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 40'd2000000000
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iINIT_DONE,
  input  logic [3:0]       iSTATE,
  input  logic             iPASS,
  input  logic             iFAIL,
  input  logic             iCOMPLETE,
  output logic             oBUSY,
  output logic             oDONE_PULSE,
  output logic [CNT_W-1:0] oCYCLES,
  output logic [7:0]       oPASS_CNT,
  output logic [7:0]       oFAIL_CNT,
  output logic             oTIMEOUT,
  output logic [3:0]       oLED
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d, cycles_inc;
  logic [7:0]         pass_cnt_q, pass_cnt_d;
  logic [7:0]         fail_cnt_q, fail_cnt_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic               pulse_q, pulse_d;
  logic [BLINK_W:0]   blink_q, blink_d;
  logic [3:0]         led_q, led_d;

  // Saturating increment of the run-duration counter.
  always_comb begin
    cycles_inc = cycles_q;
    if (cycles_q != {CNT_W{1'b1}}) begin
      cycles_inc = cycles_q + 1'b1;
    end
  end

  // Next-state and result logic; everything defaults to holding its value.
  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    pulse_d    = 1'b0;
    blink_d    = blink_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (iINIT_DONE && (iSTATE != 4'd0)) begin
          state_d   = ST_RUN;
          cycles_d  = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Completion beats a simultaneous driver reset and the watchdog.
        if (iCOMPLETE) begin
          state_d = ST_DONE;
          pulse_d = 1'b1;
          if (iPASS && !iFAIL) begin
            pass_d = 1'b1;
            if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
          end else begin
            fail_d = 1'b1;
            if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          end
        end else if (iSTATE == 4'd0) begin
          // Driver was reset mid-run: drop the run silently.
          state_d = ST_IDLE;
        end else begin
          cycles_d = cycles_inc;
`ifdef DDR_TEST_TIMEOUT_EN
          if (cycles_inc == TIMEOUT_CYCLES) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
            pulse_d   = 1'b1;
            if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          end
`endif
        end
      end
      ST_DONE: begin
        if (iSTATE == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifndef DDR_TEST_TIMEOUT_EN
  // Watchdog limit has no consumer when the watchdog is compiled out.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  // LED image computed from next-state values so it lines up with the FSM.
  always_comb begin
    led_d    = '0;
    led_d[0] = iINIT_DONE;
    led_d[1] = (state_d == ST_RUN) ? blink_d[BLINK_W] : 1'b0;
    led_d[2] = pass_d;
    led_d[3] = fail_d | (timeout_d & blink_d[BLINK_W-2]);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      cycles_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      pulse_q    <= 1'b0;
      blink_q    <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      pulse_q    <= pulse_d;
      blink_q    <= blink_d;
      led_q      <= led_d;
    end
  end

  assign oBUSY       = (state_q == ST_RUN);
  assign oDONE_PULSE = pulse_q;
  assign oCYCLES     = cycles_q;
  assign oPASS_CNT   = pass_cnt_q;
  assign oFAIL_CNT   = fail_cnt_q;
  assign oTIMEOUT    = timeout_q;
  assign oLED        = led_q;

endmodule

// File: tb/tb_ddr3_test_status_reporter.sv
// Testbench for ddr3_test_status_reporter (BLINK_W shrunk so blinking is visible).
// Build with DDR_TEST_TIMEOUT_EN defined to exercise the watchdog (limit 100).
module tb_ddr3_test_status_reporter;

  localparam int CNT_W   = 40;
  localparam int BLINK_W = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             init_done;
  logic [3:0]       state;
  logic             pass;
  logic             fail;
  logic             complete;
  logic             busy;
  logic             done_pulse;
  logic [CNT_W-1:0] cycles;
  logic [7:0]       pass_cnt;
  logic [7:0]       fail_cnt;
  logic             timeout;
  logic [3:0]       led;

  ddr3_test_status_reporter #(
    .CNT_W         (CNT_W),
    .BLINK_W       (BLINK_W),
    .TIMEOUT_CYCLES(40'd100)
  ) dut (
    .iCLK       (clk),
    .iRST_n     (rst_n),
    .iINIT_DONE (init_done),
    .iSTATE     (state),
    .iPASS      (pass),
    .iFAIL      (fail),
    .iCOMPLETE  (complete),
    .oBUSY      (busy),
    .oDONE_PULSE(done_pulse),
    .oCYCLES    (cycles),
    .oPASS_CNT  (pass_cnt),
    .oFAIL_CNT  (fail_cnt),
    .oTIMEOUT   (timeout),
    .oLED       (led)
  );

  // Edges since reset release: the value the free-running blink counter holds.
  int edge_n;
  always @(posedge clk) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // reference model: results of the last run, derived from run outcomes
  int      checks = 0;
  int      errors = 0;
  longint  m_cycles;
  int      m_pass_cnt;
  int      m_fail_cnt;
  bit      m_pass;
  bit      m_fail;
  bit      m_timeout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_reset();
    m_cycles   = 0;
    m_pass_cnt = 0;
    m_fail_cnt = 0;
    m_pass     = 0;
    m_fail     = 0;
    m_timeout  = 0;
  endtask

  // Compare every output against the model; called right after a negedge.
  task automatic check_all(input string tag, input bit exp_busy, input bit exp_pulse);
    bit exp_l1, exp_l3;
    exp_l1 = exp_busy ? bit'((edge_n >> BLINK_W) & 1) : 1'b0;
    exp_l3 = m_fail | (m_timeout & bit'((edge_n >> (BLINK_W - 2)) & 1));
    check({tag, ".busy"},  64'(busy),       64'(exp_busy));
    check({tag, ".pulse"}, 64'(done_pulse), 64'(exp_pulse));
    check({tag, ".cyc"},   64'(cycles),     64'(m_cycles));
    check({tag, ".pcnt"},  64'(pass_cnt),   64'(m_pass_cnt));
    check({tag, ".fcnt"},  64'(fail_cnt),   64'(m_fail_cnt));
    check({tag, ".tmo"},   64'(timeout),    64'(m_timeout));
    check({tag, ".led0"},  64'(led[0]),     64'(init_done));
    check({tag, ".led1"},  64'(led[1]),     64'(exp_l1));
    check({tag, ".led2"},  64'(led[2]),     64'(m_pass));
    check({tag, ".led3"},  64'(led[3]),     64'(exp_l3));
  endtask

  // One driver run: start, n_inc non-completing edges, then finish.
  // kind: 0 pass, 1 fail, 2 pass+fail both high, 3 driver abort.
  task automatic do_run(input int n_inc, input int kind);
    init_done = 1'b1;
    state     = 4'($urandom_range(1, 15));
    complete  = 1'b0;
    pass      = 1'b0;
    fail      = 1'b0;
    @(negedge clk);
    m_cycles  = 0;
    m_pass    = 0;
    m_fail    = 0;
    m_timeout = 0;
    check_all("start", 1'b1, 1'b0);
    for (int i = 0; i < n_inc; i++) begin
      state     = 4'($urandom_range(1, 15));
      init_done = 1'($urandom_range(0, 1));
      pass      = 1'($urandom_range(0, 1));
      fail      = 1'($urandom_range(0, 1));
      @(negedge clk);
      m_cycles++;
      check_all("run", 1'b1, 1'b0);
    end
    if (kind == 3) begin
      state = 4'd0;
      pass  = 1'b0;
      fail  = 1'b0;
      @(negedge clk);
      check_all("abort", 1'b0, 1'b0);
    end else begin
      complete = 1'b1;
      pass     = (kind == 0) || (kind == 2);
      fail     = (kind != 0);
      state    = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (kind == 0) begin
        m_pass     = 1;
        m_pass_cnt = sat_inc(m_pass_cnt);
      end else begin
        m_fail     = 1;
        m_fail_cnt = sat_inc(m_fail_cnt);
      end
      check_all("done", 1'b0, 1'b1);
      complete = 1'b0;
      pass     = 1'b0;
      fail     = 1'b0;
      state    = 4'd0;
      @(negedge clk);
      check_all("to_idle", 1'b0, 1'b0);
    end
  endtask

  // main directed sequence
  initial begin
    rst_n     = 1'b0;
    init_done = 1'b0;
    state     = 4'd0;
    pass      = 1'b0;
    fail      = 1'b0;
    complete  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("in_reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all("idle20", 1'b0, 1'b0);
    check("idle20.led", 64'(led), 64'd0);

    // iSTATE!=0 before edge 0, completion first seen at edge 10 -> 9 cycles
    do_run(9, 0);
    do_run(9, 1);
    do_run(5, 0);
    check("pass_led_after_fail", 64'(led[3:2]), 64'b01);
    do_run(4, 3);
    do_run(2, 2);
    do_run(0, 0);
    do_run(40, 0);

    // init done low in IDLE blocks the start
    init_done = 1'b0;
    state     = 4'd5;
    repeat (3) @(negedge clk);
    check_all("no_init", 1'b0, 1'b0);
    state = 4'd0;
    @(negedge clk);

    repeat (20) do_run($urandom_range(0, 12), $urandom_range(0, 3));

    // reset mid-run discards everything
    init_done = 1'b1;
    state     = 4'd3;
    repeat (4) @(negedge clk);
    rst_n     = 1'b0;
    init_done = 1'b0;
    state     = 4'd0;
    @(negedge clk);
    model_reset();
    check_all("mid_reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_all("post_reset", 1'b0, 1'b0);

`ifdef DDR_TEST_TIMEOUT_EN
    begin
      int n;
      bit seen;
      init_done = 1'b1;
      state     = 4'd2;
      complete  = 1'b0;
      @(negedge clk);
      m_cycles = 0; m_pass = 0; m_fail = 0; m_timeout = 0;
      check_all("to_start", 1'b1, 1'b0);
      n    = 0;
      seen = 0;
      for (int i = 1; i <= 200; i++) begin
        @(negedge clk);
        if (done_pulse) begin
          n    = i;
          seen = 1;
          break;
        end
      end
      check("to_seen", 64'(seen), 64'd1);
      check("to_edges", 64'(n), 64'd100);
      m_cycles   = 100;
      m_timeout  = 1;
      m_fail_cnt = sat_inc(m_fail_cnt);
      check_all("to_done", 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check_all("to_blink", 1'b0, 1'b0);
      end
      state = 4'd0;
      @(negedge clk);
      check_all("to_idle", 1'b0, 1'b0);
    end
`endif

    // long string of failing runs: fail counter sticks at 255
    repeat (260) do_run($urandom_range(0, 2), 1);
    check("fail_sat", 64'(fail_cnt), 64'd255);
    do_run(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard stop if the sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog observed=stalled expected=finished");
    $fatal(1, "bench stalled");
  end

endmodule
